// File: rtl/vx_tcu_drl_mask_seq_if.sv
// rtl/vx_tcu_drl_mask_seq_if.sv - request/beat handshake bundle for the DRL lane-mask sequencer
//
// Request side : in_valid, in_ready, in_vld_mask[IN_W], in_fmt[3]
// Beat side    : out_valid, out_ready, out_lane_mask[TCK], out_beat[BEAT_W],
//                out_cnt[CNT_W], out_last
// master = request producer / beat consumer, slave = the sequencer.
interface vx_tcu_drl_mask_seq_if #(
  parameter int TCK    = 4,
  parameter int STRIDE = 4,
  parameter int BEATS  = 2
);
  localparam int IN_W   = TCK * STRIDE * BEATS;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(TCK + 1);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_vld_mask;
  logic [2:0]        in_fmt;
  logic              out_valid;
  logic              out_ready;
  logic [TCK-1:0]    out_lane_mask;
  logic [BEAT_W-1:0] out_beat;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_last;

  modport master (
    output in_valid, in_vld_mask, in_fmt, out_ready,
    input  in_ready, out_valid, out_lane_mask, out_beat, out_cnt, out_last
  );

  modport slave (
    input  in_valid, in_vld_mask, in_fmt, out_ready,
    output in_ready, out_valid, out_lane_mask, out_beat, out_cnt, out_last
  );
endinterface

// File: rtl/vx_tcu_drl_mask_seq.sv
// rtl/vx_tcu_drl_mask_seq.sv - multi-beat TCU DRL lane-mask sequencer
//
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of vx_tcu_drl_mask_seq_if
//              (request in_valid/in_ready/in_vld_mask/in_fmt,
//               beat out_valid/out_ready/out_lane_mask/out_beat/out_cnt/out_last)
//
// A request (mask + fmt) is captured into holding registers. Every beat output
// is derived only from those registers plus a beat cursor, so all outputs are
// stable while out_ready is low and have no combinational input dependency.
module vx_tcu_drl_mask_seq #(
  parameter int N          = 2,
  parameter int TCK        = 2 * N,
  parameter int STRIDE     = 4,
  parameter int BEATS      = 2,
  parameter int SKIP_EMPTY = 1,
  parameter logic [2:0] TCU_FP32_ID = 3'd0,
  parameter logic [2:0] TCU_FP16_ID = 3'd1,
  parameter logic [2:0] TCU_BF16_ID = 3'd2,
  parameter logic [2:0] TCU_I8_ID   = 3'd3,
  parameter logic [2:0] TCU_U8_ID   = 3'd4
) (
  input  logic clk,
  input  logic reset_n,
  vx_tcu_drl_mask_seq_if.slave bus
);
  localparam int IN_W   = TCK * STRIDE * BEATS;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(TCK + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [IN_W-1:0]   mask_q;
  logic [2:0]        fmt_q;
  logic [BEAT_W-1:0] cursor;   // lowest beat still eligible for presentation

  logic [TCK-1:0]    beat_mask [BEATS];
  logic [BEATS-1:0]  nz;
  logic              fmt_ok;
  logic [BEAT_W-1:0] sel;
  logic              last;
  logic              found;
  logic              running;
  logic [TCK-1:0]    lane_mask;
  logic [CNT_W-1:0]  cnt;
  logic              in_fire;
  logic              out_fire;

  // Per-beat physical lane masks from the held request.
  always_comb begin
    fmt_ok = 1'b0;
    case (fmt_q)
      TCU_FP32_ID, TCU_FP16_ID, TCU_BF16_ID, TCU_I8_ID, TCU_U8_ID: fmt_ok = 1'b1;
      default: fmt_ok = 1'b0;
    endcase
    for (int b = 0; b < BEATS; b++) begin
      beat_mask[b] = '0;
      for (int i = 0; i < TCK; i++) begin
        case (fmt_q)
          TCU_FP32_ID: beat_mask[b][i] = ((i % 2) == 0) ? mask_q[(b*TCK+i)*STRIDE] : 1'b0;
          TCU_FP16_ID, TCU_BF16_ID: beat_mask[b][i] = mask_q[(b*TCK+i)*STRIDE];
          TCU_I8_ID, TCU_U8_ID: beat_mask[b][i] = |mask_q[(b*TCK+i)*STRIDE +: STRIDE];
          default: beat_mask[b][i] = 1'b0;
        endcase
      end
      nz[b] = |beat_mask[b];
    end
  end

  // Beat selection from the cursor. With skipping, the presented beat is the
  // first nonzero beat at or after the cursor; an all-zero request falls
  // through to beat 0 with last set.
  always_comb begin
    sel   = cursor;
    last  = 1'b1;
    found = 1'b0;
    if (!fmt_ok) begin
      sel  = '0;
      last = 1'b1;
    end else if (SKIP_EMPTY == 0) begin
      sel  = cursor;
      last = (int'(cursor) == BEATS - 1);
    end else begin
      for (int b = 0; b < BEATS; b++) begin
        if (!found && (b >= int'(cursor)) && nz[b]) begin
          sel   = BEAT_W'(b);
          found = 1'b1;
        end
      end
      for (int b = 0; b < BEATS; b++) begin
        if ((b > int'(sel)) && nz[b]) last = 1'b0;
      end
    end
  end

  always_comb begin
    running   = (state == RUN);
    lane_mask = running ? beat_mask[sel] : '0;
    cnt       = '0;
    for (int i = 0; i < TCK; i++) cnt = cnt + CNT_W'(lane_mask[i]);
  end

  assign out_fire = running && bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;

  assign bus.in_ready      = (state == IDLE) || (out_fire && last);
  assign bus.out_valid     = running;
  assign bus.out_lane_mask = lane_mask;
  assign bus.out_cnt       = cnt;
  assign bus.out_beat      = running ? sel : '0;
  assign bus.out_last      = running && last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      mask_q <= '0;
      fmt_q  <= '0;
      cursor <= '0;
    end else if (in_fire) begin
      // Covers both the idle accept and the zero-bubble accept on a last beat.
      state  <= RUN;
      mask_q <= bus.in_vld_mask;
      fmt_q  <= bus.in_fmt;
      cursor <= '0;
    end else if (out_fire) begin
      if (last) state <= IDLE;
      else      cursor <= sel + BEAT_W'(1);
    end
  end
endmodule
